// File: rtl/cache_dm_ctrl.sv
// Direct-mapped, write-through/no-allocate cache controller with a flush request.
// Define CACHE_DM_CTRL_STATS_EN to add saturating read hit/miss counters.
module cache_dm_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LINES  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cpu_valid_i,
  output logic                  cpu_ready_o,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_adr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                  cpu_resp_valid_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_adr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  flush_i
`ifdef CACHE_DM_CTRL_STATS_EN
  ,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;

  typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, RESP} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    hit_q, hit_d;
  logic                    flush_pend_q, flush_pend_d;
  logic [NUM_LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q  [NUM_LINES];
  logic [DATA_WIDTH-1:0]   data_q [NUM_LINES];

  logic [IDX_W-1:0]        cpu_idx, lat_idx;
  logic [TAG_W-1:0]        cpu_tag, lat_tag;
  logic                    lookup_hit;
  logic                    fill_en, upd_en;

  assign cpu_idx    = cpu_adr_i[IDX_W-1:0];
  assign cpu_tag    = cpu_adr_i[ADDR_WIDTH-1:IDX_W];
  assign lat_idx    = adr_q[IDX_W-1:0];
  assign lat_tag    = adr_q[ADDR_WIDTH-1:IDX_W];
  assign lookup_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  assign cpu_ready_o      = (state_q == IDLE) && !flush_i && !flush_pend_q;
  assign cpu_resp_valid_o = (state_q == RESP);
  assign cpu_rdata_o      = rdata_q;
  assign mem_valid_o      = (state_q == MEM_RD) || (state_q == MEM_WR);
  assign mem_we_o         = (state_q == MEM_WR);
  assign mem_adr_o        = adr_q;
  assign mem_wdata_o      = wdata_q;

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    hit_d        = hit_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    fill_en      = 1'b0;
    upd_en       = 1'b0;

    // A flush seen mid-transaction is remembered and applied once back in IDLE.
    if (flush_i && state_q != IDLE) flush_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (flush_i || flush_pend_q) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end else if (cpu_valid_i) begin
          adr_d   = cpu_adr_i;
          wdata_d = cpu_wdata_i;
          hit_d   = lookup_hit;
          if (cpu_we_i) begin
            state_d = MEM_WR;
          end else if (lookup_hit) begin
            rdata_d = data_q[cpu_idx];
            state_d = RESP;
          end else begin
            state_d = MEM_RD;
          end
        end
      end
      MEM_RD: begin
        if (mem_ready_i) begin
          fill_en          = 1'b1;
          valid_d[lat_idx] = 1'b1;
          rdata_d          = mem_rdata_i;
          state_d          = RESP;
        end
      end
      MEM_WR: begin
        if (mem_ready_i) begin
          upd_en  = hit_q;
          rdata_d = wdata_q;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      adr_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      hit_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      hit_q        <= hit_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
    end
  end

  // Tag/data storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      data_q[lat_idx] <= mem_rdata_i;
      tag_q[lat_idx]  <= lat_tag;
    end else if (upd_en) begin
      data_q[lat_idx] <= wdata_q;
    end
  end

`ifdef CACHE_DM_CTRL_STATS_EN
  logic        rd_accept;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  assign rd_accept  = cpu_valid_i && cpu_ready_o && !cpu_we_i;
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rd_accept) begin
      if (lookup_hit && hit_cnt_q != 32'hFFFF_FFFF)   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (!lookup_hit && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_dm_ctrl.sv
// Directed self-checking bench for cache_dm_ctrl (default parameters, 16 lines).
// Stats checks are compiled in when CACHE_DM_CTRL_STATS_EN is defined.
module tb_cache_dm_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cpu_valid_i, cpu_ready_o, cpu_we_i, cpu_resp_valid_o;
  logic [15:0] cpu_adr_i;
  logic [31:0] cpu_wdata_i, cpu_rdata_o;
  logic        mem_valid_o, mem_ready_i, mem_we_o;
  logic [15:0] mem_adr_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;
  logic        flush_i;
`ifdef CACHE_DM_CTRL_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  int          obsMemReqs, obsLat;
  logic [15:0] obsMemAdr;
  logic        obsMemWe, obsStable, obsRespAfter;
  logic [31:0] obsMemWdata, obsRdata;

  always #5 clk_i = ~clk_i;

  cache_dm_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cpu_valid_i(cpu_valid_i), .cpu_ready_o(cpu_ready_o), .cpu_we_i(cpu_we_i),
    .cpu_adr_i(cpu_adr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
    .cpu_resp_valid_o(cpu_resp_valid_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
    .mem_adr_o(mem_adr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .flush_i(flush_i)
`ifdef CACHE_DM_CTRL_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  task automatic apply_reset();
    rst_ni = 1'b0;
    cpu_valid_i = 0; cpu_we_i = 0; cpu_adr_i = '0; cpu_wdata_i = '0;
    mem_ready_i = 0; mem_rdata_i = '0; flush_i = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  // Issue one request, act as memory (memWait stall cycles), record what happened.
  task automatic do_txn(input logic we, input logic [15:0] adr, input logic [31:0] wdata,
                        input int memWait, input logic [31:0] memData);
    int  waitCnt, guard;
    bit  got;
    obsMemReqs = 0; obsLat = 0; obsStable = 1; obsRespAfter = 0;
    obsRdata = '0; obsMemAdr = '0; obsMemWe = 0; obsMemWdata = '0;
    cpu_valid_i = 1; cpu_we_i = we; cpu_adr_i = adr; cpu_wdata_i = wdata;
    guard = 0;
    while (!cpu_ready_o && guard < 20) begin @(posedge clk_i); #1; guard++; end
    @(posedge clk_i); #1;
    cpu_valid_i = 0; cpu_we_i = 0;
    waitCnt = 0; got = 0;
    for (int c = 1; c <= 60 && !got; c++) begin
      if (cpu_resp_valid_o) begin
        obsRdata = cpu_rdata_o; obsLat = c; got = 1;
      end else if (mem_valid_o) begin
        if (waitCnt == 0) begin
          obsMemAdr = mem_adr_o; obsMemWe = mem_we_o; obsMemWdata = mem_wdata_o;
        end else if (mem_adr_o !== obsMemAdr || mem_we_o !== obsMemWe || mem_wdata_o !== obsMemWdata) begin
          obsStable = 0;
        end
        if (waitCnt == memWait) begin
          mem_ready_i = 1; mem_rdata_i = memData; obsMemReqs++;
        end
        waitCnt++;
      end
      if (!got) begin @(posedge clk_i); #1; mem_ready_i = 0; mem_rdata_i = '0; end
    end
    if (got) begin @(posedge clk_i); #1; obsRespAfter = cpu_resp_valid_o; end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (cpu_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got %b want 1", cpu_ready_o); end
    checks++; if (cpu_resp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp got %b want 0", cpu_resp_valid_o); end
    checks++; if (cpu_rdata_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata got %h want 0", cpu_rdata_o); end
    checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_valid got %b want 0", mem_valid_o); end
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_we got %b want 0", mem_we_o); end
    checks++; if (mem_adr_o !== 16'h0) begin errors++; $display("[TB] FAIL rst_mem_adr got %h want 0", mem_adr_o); end
    checks++; if (mem_wdata_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_mem_wdata got %h want 0", mem_wdata_o); end
  endtask

  task automatic test_read_miss_hit();
    do_txn(0, 16'h0012, 32'h0, 3, 32'hDEADBEEF);
    checks++; if (obsMemReqs !== 1) begin errors++; $display("[TB] FAIL cold_memreqs got %0d want 1", obsMemReqs); end
    checks++; if (obsMemAdr !== 16'h0012) begin errors++; $display("[TB] FAIL cold_adr got %h want 0012", obsMemAdr); end
    checks++; if (obsMemWe !== 1'b0) begin errors++; $display("[TB] FAIL cold_we got %b want 0", obsMemWe); end
    checks++; if (obsStable !== 1'b1) begin errors++; $display("[TB] FAIL cold_stable got %b want 1", obsStable); end
    checks++; if (obsRdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL cold_rdata got %h want deadbeef", obsRdata); end
    checks++; if (obsLat !== 5) begin errors++; $display("[TB] FAIL cold_lat got %0d want 5", obsLat); end
    checks++; if (obsRespAfter !== 1'b0) begin errors++; $display("[TB] FAIL cold_resp_one got %b want 0", obsRespAfter); end
    checks++; if (cpu_rdata_o !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rdata_hold got %h want deadbeef", cpu_rdata_o); end
    do_txn(0, 16'h0012, 32'h0, 0, 32'h0);
    checks++; if (obsMemReqs !== 0) begin errors++; $display("[TB] FAIL hit_memreqs got %0d want 0", obsMemReqs); end
    checks++; if (obsLat !== 1) begin errors++; $display("[TB] FAIL hit_lat got %0d want 1", obsLat); end
    checks++; if (obsRdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL hit_rdata got %h want deadbeef", obsRdata); end
  endtask

  task automatic test_write_hit();
    do_txn(1, 16'h0012, 32'h11223344, 1, 32'h0);
    checks++; if (obsMemReqs !== 1) begin errors++; $display("[TB] FAIL wr_memreqs got %0d want 1", obsMemReqs); end
    checks++; if (obsMemAdr !== 16'h0012) begin errors++; $display("[TB] FAIL wr_adr got %h want 0012", obsMemAdr); end
    checks++; if (obsMemWe !== 1'b1) begin errors++; $display("[TB] FAIL wr_we got %b want 1", obsMemWe); end
    checks++; if (obsMemWdata !== 32'h11223344) begin errors++; $display("[TB] FAIL wr_wdata got %h want 11223344", obsMemWdata); end
    checks++; if (obsRdata !== 32'h11223344) begin errors++; $display("[TB] FAIL wr_rdata got %h want 11223344", obsRdata); end
    checks++; if (obsLat !== 3) begin errors++; $display("[TB] FAIL wr_lat got %0d want 3", obsLat); end
    do_txn(0, 16'h0012, 32'h0, 0, 32'h0);
    checks++; if (obsMemReqs !== 0) begin errors++; $display("[TB] FAIL wrhit_memreqs got %0d want 0", obsMemReqs); end
    checks++; if (obsRdata !== 32'h11223344) begin errors++; $display("[TB] FAIL wrhit_rdata got %h want 11223344", obsRdata); end
  endtask

  task automatic test_eviction();
    do_txn(0, 16'h0022, 32'h0, 0, 32'hAAAA0022);
    checks++; if (obsMemReqs !== 1) begin errors++; $display("[TB] FAIL ev22_memreqs got %0d want 1", obsMemReqs); end
    checks++; if (obsLat !== 2) begin errors++; $display("[TB] FAIL ev22_lat got %0d want 2", obsLat); end
    do_txn(0, 16'h0012, 32'h0, 0, 32'h55550012);
    checks++; if (obsMemReqs !== 1) begin errors++; $display("[TB] FAIL ev12_memreqs got %0d want 1", obsMemReqs); end
    checks++; if (obsRdata !== 32'h55550012) begin errors++; $display("[TB] FAIL ev12_rdata got %h want 55550012", obsRdata); end
  endtask

  task automatic test_no_allocate();
    do_txn(1, 16'h0030, 32'hCAFE0030, 0, 32'h0);
    checks++; if (obsMemReqs !== 1 || obsMemWe !== 1'b1) begin errors++; $display("[TB] FAIL na_wr got reqs %0d we %b want 1 1", obsMemReqs, obsMemWe); end
    do_txn(0, 16'h0030, 32'h0, 0, 32'h0BADF00D);
    checks++; if (obsMemReqs !== 1) begin errors++; $display("[TB] FAIL na_rd_memreqs got %0d want 1", obsMemReqs); end
    checks++; if (obsRdata !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL na_rd_rdata got %h want 0badf00d", obsRdata); end
  endtask

  task automatic test_flush();
    do_txn(0, 16'h0005, 32'h0, 0, 32'h01010105);
    do_txn(0, 16'h0005, 32'h0, 0, 32'h0);
    checks++; if (obsMemReqs !== 0) begin errors++; $display("[TB] FAIL fl_prehit got %0d want 0", obsMemReqs); end
    cpu_valid_i = 1; cpu_we_i = 0; cpu_adr_i = 16'h0007;
    @(posedge clk_i); #1;
    cpu_valid_i = 0; flush_i = 1;
    @(posedge clk_i); #1;
    flush_i = 0; mem_ready_i = 1; mem_rdata_i = 32'h07070707;
    @(posedge clk_i); #1;
    mem_ready_i = 0; mem_rdata_i = '0;
    checks++; if (cpu_resp_valid_o !== 1'b1 || cpu_rdata_o !== 32'h07070707) begin errors++; $display("[TB] FAIL fl_resp got %b %h want 1 07070707", cpu_resp_valid_o, cpu_rdata_o); end
    @(posedge clk_i); #1;
    checks++; if (cpu_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL fl_pend_ready got %b want 0", cpu_ready_o); end
    @(posedge clk_i); #1;
    checks++; if (cpu_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL fl_after_ready got %b want 1", cpu_ready_o); end
    do_txn(0, 16'h0005, 32'h0, 0, 32'h05050505);
    checks++; if (obsMemReqs !== 1) begin errors++; $display("[TB] FAIL fl_miss5 got %0d want 1", obsMemReqs); end
    do_txn(0, 16'h0007, 32'h0, 0, 32'h77777777);
    checks++; if (obsMemReqs !== 1) begin errors++; $display("[TB] FAIL fl_miss7 got %0d want 1", obsMemReqs); end
    flush_i = 1; cpu_valid_i = 1; cpu_adr_i = 16'h0007; #1;
    checks++; if (cpu_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL fl_idle_ready got %b want 0", cpu_ready_o); end
    @(posedge clk_i); #1;
    flush_i = 0; cpu_valid_i = 0;
    checks++; if (cpu_resp_valid_o !== 1'b0 || mem_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL fl_idle_noaccept got resp %b memv %b want 0 0", cpu_resp_valid_o, mem_valid_o); end
    do_txn(0, 16'h0007, 32'h0, 0, 32'h77777777);
    checks++; if (obsMemReqs !== 1) begin errors++; $display("[TB] FAIL fl_idle_miss7 got %0d want 1", obsMemReqs); end
  endtask

  task automatic test_reset_mid();
    logic sawResp;
    cpu_valid_i = 1; cpu_we_i = 0; cpu_adr_i = 16'h0009;
    @(posedge clk_i); #1;
    cpu_valid_i = 0;
    checks++; if (mem_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL rm_memv_before got %b want 1", mem_valid_o); end
    #1 rst_ni = 0;
    #1;
    checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rm_memv_fall got %b want 0", mem_valid_o); end
    mem_ready_i = 1; mem_rdata_i = 32'h99999999;
    sawResp = 0;
    repeat (2) begin @(posedge clk_i); #1; if (cpu_resp_valid_o) sawResp = 1; end
    mem_ready_i = 0; mem_rdata_i = '0;
    @(negedge clk_i); rst_ni = 1;
    repeat (3) begin @(posedge clk_i); #1; if (cpu_resp_valid_o) sawResp = 1; end
    checks++; if (sawResp !== 1'b0) begin errors++; $display("[TB] FAIL rm_noresp got %b want 0", sawResp); end
    checks++; if (cpu_rdata_o !== 32'h0) begin errors++; $display("[TB] FAIL rm_rdata got %h want 0", cpu_rdata_o); end
    do_txn(0, 16'h0009, 32'h0, 0, 32'h09090909);
    checks++; if (obsMemReqs !== 1 || obsRdata !== 32'h09090909) begin errors++; $display("[TB] FAIL rm_miss9 got %0d %h want 1 09090909", obsMemReqs, obsRdata); end
    do_txn(0, 16'h0007, 32'h0, 0, 32'h70707070);
    checks++; if (obsMemReqs !== 1) begin errors++; $display("[TB] FAIL rm_miss7 got %0d want 1", obsMemReqs); end
  endtask

`ifdef CACHE_DM_CTRL_STATS_EN
  task automatic test_stats();
    apply_reset();
    checks++; if (hit_cnt_o !== 0 || miss_cnt_o !== 0) begin errors++; $display("[TB] FAIL st_init got %0d %0d want 0 0", hit_cnt_o, miss_cnt_o); end
    do_txn(0, 16'h0040, 32'h0, 0, 32'h40404040);
    do_txn(0, 16'h0040, 32'h0, 0, 32'h0);
    do_txn(0, 16'h0041, 32'h0, 0, 32'h41414141);
    do_txn(1, 16'h0041, 32'h12345678, 0, 32'h0);
    do_txn(0, 16'h0041, 32'h0, 0, 32'h0);
    do_txn(0, 16'h0042, 32'h0, 0, 32'h42424242);
    checks++; if (hit_cnt_o !== 32'd2) begin errors++; $display("[TB] FAIL st_hits got %0d want 2", hit_cnt_o); end
    checks++; if (miss_cnt_o !== 32'd3) begin errors++; $display("[TB] FAIL st_misses got %0d want 3", miss_cnt_o); end
    apply_reset();
    checks++; if (hit_cnt_o !== 0 || miss_cnt_o !== 0) begin errors++; $display("[TB] FAIL st_reset got %0d %0d want 0 0", hit_cnt_o, miss_cnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_hit();
    test_eviction();
    test_no_allocate();
    test_flush();
    test_reset_mid();
`ifdef CACHE_DM_CTRL_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_dm_ctrl.md
CACHE_DM_CTRL -- requirements
Module: cache_dm_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter NUM_LINES, default 16, cache lines (one word each); power of 2, >=2, log2(NUM_LINES) < ADDR_WIDTH.
REQ-004 SHALL have ports: clk_i  in  1  sole clock, rising edge; rst_ni  in  1  asynchronous active-low reset.
REQ-005 SHALL have CPU ports: cpu_valid_i in 1 request; cpu_ready_o out 1 accept; cpu_we_i in 1 write; cpu_adr_i in ADDR_WIDTH; cpu_wdata_i in DATA_WIDTH; cpu_rdata_o out DATA_WIDTH; cpu_resp_valid_o out 1 response strobe.
REQ-006 SHALL have memory ports: mem_valid_o out 1; mem_ready_i in 1; mem_we_o out 1; mem_adr_o out ADDR_WIDTH; mem_wdata_o out DATA_WIDTH; mem_rdata_i in DATA_WIDTH.
REQ-007 SHALL have flush_i  in  1  invalidate-all request, level sampled each cycle.

Function
REQ-008 SHALL be direct-mapped: index = cpu_adr_i[IDX_W-1:0], tag = cpu_adr_i[ADDR_WIDTH-1:IDX_W], IDX_W = log2(NUM_LINES); per line: valid bit, tag, data.
REQ-009 SHALL use states IDLE, MEM_RD, MEM_WR, RESP; request accepted on edge where cpu_valid_i && cpu_ready_o.
REQ-010 SHALL drive cpu_ready_o = (state==IDLE) && !flush_i && !flush_pending (combinational).
REQ-011 SHALL latch adr/we/wdata at accept; hit = line valid && tag equal, evaluated at accept.
REQ-012 Read hit: IDLE->RESP; cpu_resp_valid_o high exactly one cycle, the cycle after accept, cpu_rdata_o = line data.
REQ-013 Read miss: IDLE->MEM_RD; mem_valid_o=1, mem_we_o=0, mem_adr_o=latched adr from the cycle after accept until mem_ready_i; on handshake edge fill line (data=mem_rdata_i, tag, valid=1), ->RESP, cpu_rdata_o = filled data.
REQ-014 Write (write-through, no-allocate): IDLE->MEM_WR; mem_valid_o=1, mem_we_o=1, mem_adr_o/mem_wdata_o = latched values until mem_ready_i; on handshake, if hit update line data, else no line change; ->RESP with cpu_rdata_o = written data.
REQ-015 mem_* outputs SHALL be stable while mem_valid_o=1 && !mem_ready_i; mem_valid_o=0 outside MEM_RD/MEM_WR.
REQ-016 RESP SHALL last one cycle then ->IDLE; max one outstanding request; hit throughput one per 2 cycles.
REQ-017 cpu_rdata_o SHALL hold its last value outside RESP; cpu_resp_valid_o=0 outside RESP.
REQ-018 flush_i high in IDLE SHALL clear all valid bits at that edge; no request accepted that cycle (flush wins over simultaneous cpu_valid_i).
REQ-019 flush_i high outside IDLE SHALL set flush_pending; applied on first IDLE cycle (ready low that cycle), then cleared; the in-flight fill still completes first.
REQ-020 Memory handshake waits SHALL be unbounded; no timeout.

Reset
REQ-021 rst_ni low SHALL asynchronously force: state=IDLE, all valid bits 0, flush_pending 0, cpu_resp_valid_o 0, cpu_rdata_o 0, mem_valid_o 0, mem_we_o 0, mem_adr_o 0, mem_wdata_o 0.
REQ-022 Reset mid-transaction SHALL abort it with no response and no line update; tag/data arrays need no reset.

Configuration
REQ-023 With macro CACHE_DM_CTRL_STATS_EN defined SHALL add outputs hit_cnt_o, miss_cnt_o (32 bits each), incremented at read accept on hit/miss, saturating at 0xFFFFFFFF, cleared by reset only (not flush); writes not counted.
REQ-024 Without CACHE_DM_CTRL_STATS_EN SHALL omit those ports and counters; all other behaviour identical.

Verification
REQ-025 Read 0x0012 cold (mem returns 0xDEADBEEF after 3 wait cycles) -> one mem read adr 0x0012, resp 0xDEADBEEF; re-read -> resp one cycle after accept, no mem access.
REQ-026 Write 0x0012=0x11223344 after fill -> mem write adr 0x0012 data 0x11223344; subsequent read hits returning 0x11223344.
REQ-027 Read 0x0012 then 0x0022 (same index 2, NUM_LINES=16) -> both miss; read 0x0012 again misses (eviction).
REQ-028 Write to uncached 0x0030 then read 0x0030 -> write goes to memory, read misses (no-allocate).
REQ-029 flush_i pulse during MEM_RD -> fill and resp complete, ready low first IDLE cycle, then re-read of all prior lines miss; flush with cpu_valid_i in IDLE -> request not accepted.
REQ-030 rst_ni low mid MEM_RD -> mem_valid_o falls immediately, no resp; with CACHE_DM_CTRL_STATS_EN, 2 hits + 3 misses -> hit_cnt_o=2, miss_cnt_o=3, zero after reset.
